instruction_buffer: RTL
=======================

// Module: instruction_buffer
// PURPOSE
//  Circular FIFO between stage_fetch and decode/dispatch. Accepts up to 4 FETCH_PACKET lanes per cycle.
//  Lanes may be sparse; e.g. with a misaligned PC lane 0 is invalid, and lanes after a taken branch are invalid.
//  Compacts the valid lanes in lane order and presents up to DISPATCH_WIDTH oldest entries to dispatch.
//  Reports free capacity back to fetch and empties on mispredict flush.
// PARAMETERS
//  IB_SIZE         16  entries; power of 2, >= FETCH_WIDTH + DISPATCH_WIDTH
//  FETCH_WIDTH      4  input lanes per cycle
//  DISPATCH_WIDTH   3  output lanes per cycle
// PORTS
//  clock            in   1                           system clock
//  reset            in   1                           synchronous, active-high
//  flush            in   1                           mispredict recovery (retire correct_branch_target.valid)
//  fetch_packet     in   FETCH_PACKET[FETCH_WIDTH]   lanes from fetch; per-lane .valid
//  ib_free_slots    out  IB_IDX_BITS+1               IB_SIZE - count; registered-state only
//  dispatch_packet  out  FETCH_PACKET[DISPATCH_WIDTH] oldest entries; lane i valid iff i < count
//  dispatch_take    out-> in  $clog2(DISPATCH_WIDTH+1) entries consumed by dispatch this cycle
// BEHAVIOUR
//  - Reset: head = tail = 0, count = 0, ib_free_slots = IB_SIZE, all dispatch_packet[i].valid = 0.
//    Storage contents are don't-care.
//  - Enqueue:
//    - n_in = popcount(fetch_packet[*].valid).
//    - The k-th valid lane (lane order) is written to slot (tail + k) mod IB_SIZE.
//    - tail += n_in.
//  - Enqueue latency: an entry written in cycle N appears on dispatch_packet no earlier than cycle N+1.
//    There is no bypass.
//  - Dequeue:
//    - dispatch_packet[i] = storage[(head + i) mod IB_SIZE], combinational from registers.
//    - Lane i valid iff i < count.
//    - n_out = min(dispatch_take, count, DISPATCH_WIDTH); head += n_out.
//    - Dispatch consumes in order. Taking lane i implies taking all lanes < i.
//  - count_next = count + n_in - n_out. Simultaneous enqueue and dequeue are legal in the same cycle.
//  - ib_free_slots is derived from the current count, not from n_out. This avoids a fetch->IB->fetch
//    combinational loop. Space freed by dequeue becomes visible the next cycle.
//  - Overflow: fetch guarantees n_in <= ib_free_slots.
//    - If violated, the entire packet is dropped (no partial write) and tail is unchanged.
//    - The simulation assertion fires.
//  - Full: count == IB_SIZE -> ib_free_slots = 0; only an all-invalid packet is accepted.
//  - Empty: count == 0 -> no output lane valid; dispatch_take is ignored.
//  - Wrap-around: pointers are IB_IDX_BITS wide and wrap mod IB_SIZE. A packet may straddle the wrap.
//  - Flush: takes priority over everything.
//    - Next cycle: head = tail = 0, count = 0; same-cycle enqueue and dequeue are discarded.
//    - Next cycle: ib_free_slots = IB_SIZE and all outputs are invalid.
//  - reset asserted mid-operation behaves exactly as flush, and also clears storage valid tracking.
//  - Branch metadata (is_branch, bp_pred_*, bp_ghr_snapshot) is stored and forwarded unmodified.
// STRUCTURE
//  - sys_defs.svh: IB_SIZE, IB_IDX_BITS (= $clog2(IB_SIZE)), DISPATCH_WIDTH, FETCH_PACKET typedef.
//    IB_IDX_BITS is already used by fetch's ib_free_slots width.
//  - Sub-module ib_lane_compact: FETCH_WIDTH valid bits -> per-lane write offset (exclusive prefix sum)
//    plus n_in. Purely combinational.
//  - Top level holds the storage array, head/tail/count registers, and the dequeue mux.
// TESTING
//  1. Reset, then all lanes invalid -> free = 16, no output valid, count stays 0.
//  2. Enqueue valid = 4'b1110 (PCs 0x4/0x8/0xC) -> next cycle out[0..2] = PCs 0x4, 0x8, 0xC; free = 13.
//  3. Fill with 4 x 4'b1111, take = 0 -> free = 0. Offer 4'b0001 -> dropped, assert fires, count = 16.
//  4. count = 3, take = 3, enqueue 4'b1111 same cycle -> next count = 4, head of output = first new PC.
//  5. head = tail = 14, enqueue 4'b1111 -> slots 14, 15, 0, 1. Take 3, then 1 -> PC order preserved.
//  6. count = 10, flush with enqueue 4'b1111 and take = 3 -> next cycle count = 0, free = 16, outputs invalid.

Source files
------------

// File: rtl/instruction_buffer_pkg.sv
// Shared types and sizes for the instruction buffer between fetch and dispatch.
//   IB_SIZE / IB_IDX_BITS : queue depth and pointer width
//   FETCH_WIDTH           : lanes offered by fetch per cycle
//   DISPATCH_WIDTH        : lanes presented to dispatch per cycle
//   fetch_packet_t        : one fetched instruction plus its branch-prediction metadata
package instruction_buffer_pkg;

  localparam int unsigned IB_SIZE        = 16;
  localparam int unsigned IB_IDX_BITS    = $clog2(IB_SIZE);
  localparam int unsigned FETCH_WIDTH    = 4;
  localparam int unsigned DISPATCH_WIDTH = 3;

  // Occupancy counter must hold IB_SIZE itself, hence the extra bit.
  localparam int unsigned CNT_BITS      = IB_IDX_BITS + 1;
  localparam int unsigned TAKE_BITS     = $clog2(DISPATCH_WIDTH + 1);
  localparam int unsigned LANE_OFS_BITS = $clog2(FETCH_WIDTH + 1);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned GHR_BITS = 8;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     inst;
    logic                is_branch;
    logic                bp_pred_taken;
    logic [XLEN-1:0]     bp_pred_target;
    logic [GHR_BITS-1:0] bp_ghr_snapshot;
  } fetch_packet_t;

endpackage

// File: rtl/ib_lane_compact.sv
// Turns the sparse fetch lane-valid mask into a dense write offset per lane.
//   lane_valid  : per-lane valid bits from fetch
//   lane_offset : exclusive prefix sum of lane_valid (offset from tail for each valid lane)
//   n_in        : number of valid lanes
module ib_lane_compact
  import instruction_buffer_pkg::*;
(
  input  logic [FETCH_WIDTH-1:0]                    lane_valid,
  output logic [FETCH_WIDTH-1:0][LANE_OFS_BITS-1:0] lane_offset,
  output logic [LANE_OFS_BITS-1:0]                  n_in
);

  // Running count of valid lanes seen so far, in lane order.
  always_comb begin
    logic [LANE_OFS_BITS-1:0] acc;
    acc         = '0;
    lane_offset = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_offset[i] = acc;
      acc            = acc + LANE_OFS_BITS'(lane_valid[i]);
    end
    n_in = acc;
  end

endmodule

// File: rtl/instruction_buffer.sv
// Circular FIFO between fetch and decode/dispatch. Compacts up to FETCH_WIDTH
// sparse lanes per cycle into the queue and presents the DISPATCH_WIDTH oldest
// entries to dispatch.
//   clock, reset    : clock, synchronous active-high reset
//   flush           : mispredict recovery, empties the queue next cycle
//   fetch_packet    : FETCH_WIDTH incoming lanes, per-lane .valid
//   ib_free_slots   : IB_SIZE - count, from registered state only
//   dispatch_packet : oldest DISPATCH_WIDTH entries, lane i valid iff i < count
//   dispatch_take   : number of entries consumed by dispatch this cycle
module instruction_buffer
  import instruction_buffer_pkg::*;
(
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  fetch_packet_t [FETCH_WIDTH-1:0]         fetch_packet,
  output logic          [CNT_BITS-1:0]            ib_free_slots,
  output fetch_packet_t [DISPATCH_WIDTH-1:0]      dispatch_packet,
  input  logic          [TAKE_BITS-1:0]           dispatch_take
);

  logic [IB_IDX_BITS-1:0] head_q, head_d;
  logic [IB_IDX_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic [CNT_BITS-1:0]    free_q, free_d;
  fetch_packet_t          storage_q [IB_SIZE];
  fetch_packet_t          storage_d [IB_SIZE];

  logic [FETCH_WIDTH-1:0]                    lane_valid;
  logic [FETCH_WIDTH-1:0][LANE_OFS_BITS-1:0] lane_offset;
  logic [LANE_OFS_BITS-1:0]                  n_in;

  logic [CNT_BITS-1:0] free_now_c;
  logic                overflow_c;
  logic [CNT_BITS-1:0] n_acc_c;
  logic [CNT_BITS-1:0] n_out_c;

  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_valid[i] = fetch_packet[i].valid;
    end
  end

  ib_lane_compact u_compact (
    .lane_valid  (lane_valid),
    .lane_offset (lane_offset),
    .n_in        (n_in)
  );

  // Pointer, occupancy and storage update. The count is the only valid
  // tracking, so clearing it on flush/reset invalidates every entry at once.
  always_comb begin
    logic [CNT_BITS-1:0]    take_ext;
    logic [IB_IDX_BITS-1:0] wr_idx;

    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    free_d    = free_q;
    storage_d = storage_q;
    wr_idx    = '0;

    free_now_c = CNT_BITS'(IB_SIZE) - count_q;
    // An oversized packet is dropped whole; no partial write.
    overflow_c = CNT_BITS'(n_in) > free_now_c;
    n_acc_c    = overflow_c ? '0 : CNT_BITS'(n_in);

    // Dispatch can never take more than is present or more than it sees.
    take_ext = CNT_BITS'(dispatch_take);
    n_out_c  = (take_ext < count_q) ? take_ext : count_q;
    if (n_out_c > CNT_BITS'(DISPATCH_WIDTH)) begin
      n_out_c = CNT_BITS'(DISPATCH_WIDTH);
    end

    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      free_d  = CNT_BITS'(IB_SIZE);
    end else begin
      if (!overflow_c) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (lane_valid[i]) begin
            wr_idx            = tail_q + IB_IDX_BITS'(lane_offset[i]);
            storage_d[wr_idx] = fetch_packet[i];
          end
        end
      end
      head_d  = head_q + IB_IDX_BITS'(n_out_c);
      tail_d  = tail_q + IB_IDX_BITS'(n_acc_c);
      count_d = count_q + n_acc_c - n_out_c;
      free_d  = CNT_BITS'(IB_SIZE) - count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CNT_BITS'(IB_SIZE);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q.
  always_ff @(posedge clock) begin
    storage_q <= storage_d;
  end

  assign ib_free_slots = free_q;

  // Dequeue mux reads only registered state, so there is no fetch->dispatch bypass.
  always_comb begin
    logic [IB_IDX_BITS-1:0] rd_idx;
    rd_idx          = '0;
    dispatch_packet = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rd_idx                   = head_q + IB_IDX_BITS'(i);
      dispatch_packet[i]       = storage_q[rd_idx];
      dispatch_packet[i].valid = CNT_BITS'(i) < count_q;
    end
  end

`ifndef SYNTHESIS
  // Fetch must never offer more lanes than the advertised free slots.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (!overflow_c)
        else $warning("instruction_buffer: %0d lanes offered with %0d free, packet dropped",
                      n_in, free_now_c);
    end
  end
`endif

endmodule
